disp_timing_gen: RTL and testbench

- Pixel-clock-domain video source that produces the HS/VS/DE timing and 8-bit-per-channel RGB test patterns.
- Sits directly upstream of the HDMI/VGA output adapter. Its RGB, HS, VS and DE outputs wire one-to-one into that adapter's IN_VGA_* inputs.
- Default timing is VGA 640x480 at 25.175 MHz. XGA (1024x768) is reached by parameter override.
- Also exports pixel/line counters and a frame-start strobe for downstream overlay logic.

---
 rtl/disp_timing_pkg.sv | 64 ++++++
 rtl/disp_pattern.sv | 51 +++++
 rtl/disp_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_disp_timing_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_timing_pkg.sv
// Shared definitions for the display timing generator: timing presets,
// colour constants, pattern-select encoding and counter widths.
package disp_timing_pkg;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit sync_pol;
  } timing_t;

  localparam timing_t VGA_640x480 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    sync_pol: 1'b0
  };

  localparam timing_t XGA_1024x768 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
    sync_pol: 1'b0
  };

  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] BLACK   = 24'h000000;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_BLACK = 2'd3
  } pat_e;

  // Colour of bar number idx, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/disp_pattern.sv
// Test-pattern colour mapper. Purely combinational; the caller registers
// the result. Optional white grid/border overlay when DISP_TIMING_GRID_EN
// is defined.
module disp_pattern
  import disp_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic [HCNT_W-1:0] h,
  input  logic [VCNT_W-1:0] v,
  input  pat_e              pat,
  input  logic [2:0]        bar_idx,
  input  logic              de,
  output logic [23:0]       rgb
);

`ifdef DISP_TIMING_GRID_EN
  logic grid_hit;

  // Grid lines every 64 pixels/lines plus a border on the last active column/row.
  always_comb begin
    grid_hit = (h[5:0] == 6'd0) || (v[5:0] == 6'd0) ||
               (int'(h) == H_ACTIVE - 1) || (int'(v) == V_ACTIVE - 1);
  end
`else
  // Only h[7:0] and v[4] drive the patterns without the grid.
  localparam int unused_active = H_ACTIVE + V_ACTIVE;
  logic unused_bits;
  assign unused_bits = ^{h[HCNT_W-1:8], v[VCNT_W-1:5], v[3:0]};
`endif

  // Select the pattern colour; blank outside the active area.
  always_comb begin
    rgb = BLACK;
    if (de) begin
      case (pat)
        PAT_BARS:  rgb = bar_colour(bar_idx);
        PAT_RAMP:  rgb = {h[7:0], h[7:0], h[7:0]};
        PAT_CHECK: rgb = (h[4] ^ v[4]) ? WHITE : BLACK;
        default:   rgb = BLACK;
      endcase
`ifdef DISP_TIMING_GRID_EN
      if (grid_hit) begin
        rgb = WHITE;
      end
`endif
    end
  end

endmodule

// File: rtl/disp_timing_gen.sv
// Display timing generator: HS/VS/DE plus RGB test patterns, one registered
// output stage after the pixel/line counters. Grid overlay is enabled with
// the DISP_TIMING_GRID_EN macro.
module disp_timing_gen
  import disp_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640x480.h_active,
  parameter int H_FP     = VGA_640x480.h_fp,
  parameter int H_SYNC   = VGA_640x480.h_sync,
  parameter int H_BP     = VGA_640x480.h_bp,
  parameter int V_ACTIVE = VGA_640x480.v_active,
  parameter int V_FP     = VGA_640x480.v_fp,
  parameter int V_SYNC   = VGA_640x480.v_sync,
  parameter int V_BP     = VGA_640x480.v_bp,
  parameter bit SYNC_POL = VGA_640x480.sync_pol
) (
  input  logic              PCK,
  input  logic              RST,
  input  logic [1:0]        PAT_SEL,
  output logic [7:0]        OUT_R,
  output logic [7:0]        OUT_G,
  output logic [7:0]        OUT_B,
  output logic              OUT_HS,
  output logic              OUT_VS,
  output logic              OUT_DE,
  output logic [HCNT_W-1:0] HCNT,
  output logic [VCNT_W-1:0] VCNT,
  output logic              FRAME_START
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W  = H_ACTIVE / 8;

  if (HTOTAL > 2048) begin : g_htotal_guard
    $error("disp_timing_gen: HTOTAL %0d exceeds 2048", HTOTAL);
  end
  if (VTOTAL > 1024) begin : g_vtotal_guard
    $error("disp_timing_gen: VTOTAL %0d exceeds 1024", VTOTAL);
  end
  if ((H_ACTIVE % 8) != 0 || H_ACTIVE < 8) begin : g_hactive_guard
    $error("disp_timing_gen: H_ACTIVE %0d must be a non-zero multiple of 8", H_ACTIVE);
  end

  logic [HCNT_W-1:0] h_q, h_d;
  logic [VCNT_W-1:0] v_q, v_d;
  logic [HCNT_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  pat_e              pat_q, pat_d;

  logic [23:0]       rgb_q, rgb_d;
  logic              de_q, de_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic              fs_q, fs_d;

  logic              h_wrap;
  logic              at_origin;
  pat_e              pat_cur;
  logic [23:0]       rgb_pat;

  // Counter advance, bar sub-counter and frame-boundary pattern latch.
  always_comb begin
    h_wrap    = (int'(h_q) == HTOTAL - 1);
    at_origin = (h_q == '0) && (v_q == '0);
    h_d       = h_wrap ? '0 : h_q + 1'b1;
    v_d       = v_q;
    if (h_wrap) begin
      v_d = (int'(v_q) == VTOTAL - 1) ? '0 : v_q + 1'b1;
    end

    bar_cnt_d = bar_cnt_q + 1'b1;
    bar_idx_d = bar_idx_q;
    if (h_wrap) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (int'(bar_cnt_q) == BAR_W - 1) begin
      bar_cnt_d = '0;
      bar_idx_d = bar_idx_q + 1'b1;
    end

    // The (0,0) pixel already uses the freshly sampled selection so the
    // whole new frame is drawn with one pattern.
    pat_cur = at_origin ? pat_e'(PAT_SEL) : pat_q;
    pat_d   = pat_cur;
  end

  // Region decode for the output stage.
  always_comb begin
    de_d   = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    hs_d   = ((int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC))
             ? SYNC_POL : ~SYNC_POL;
    vs_d   = ((int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC))
             ? SYNC_POL : ~SYNC_POL;
    hcnt_d = h_q;
    vcnt_d = v_q;
    fs_d   = at_origin;
    rgb_d  = rgb_pat;
  end

  disp_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pattern (
    .h       (h_q),
    .v       (v_q),
    .pat     (pat_cur),
    .bar_idx (bar_idx_q),
    .de      (de_d),
    .rgb     (rgb_pat)
  );

  // Counter state; reset restarts the raster at (0,0) with colour bars.
  always_ff @(posedge PCK) begin
    if (RST) begin
      h_q       <= '0;
      v_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pat_q     <= PAT_BARS;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
    end
  end

  // Output stage; reset blanks immediately and drops any sync pulse.
  always_ff @(posedge PCK) begin
    if (RST) begin
      rgb_q  <= '0;
      de_q   <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      hcnt_q <= '0;
      vcnt_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      fs_q   <= fs_d;
    end
  end

  assign {OUT_R, OUT_G, OUT_B} = rgb_q;
  assign OUT_DE      = de_q;
  assign OUT_HS      = hs_q;
  assign OUT_VS      = vs_q;
  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_disp_timing_gen.sv
// Bench for disp_timing_gen: default VGA instance for line-level checks,
// XGA instance for the override, and a small-raster instance compared every
// cycle against a frame-arithmetic reference model.
module tb_disp_timing_gen;
  import disp_timing_pkg::*;

  localparam int SHA = 64, SHFP = 4, SHS = 8, SHBP = 4;
  localparam int SVA = 40, SVFP = 2, SVS = 3, SVBP = 3;
  localparam int SHT = SHA + SHFP + SHS + SHBP;
  localparam int SVT = SVA + SVFP + SVS + SVBP;
  localparam int SFRAME = SHT * SVT;
  localparam bit SPOL = 1'b1;

  logic       PCK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] PAT_SEL = 2'd0;

  logic [7:0]  d_r, d_g, d_b, x_r, x_g, x_b, s_r, s_g, s_b;
  logic        d_hs, d_vs, d_de, d_fs, x_hs, x_vs, x_de, x_fs, s_hs, s_vs, s_de, s_fs;
  logic [10:0] d_hcnt, x_hcnt, s_hcnt;
  logic [9:0]  d_vcnt, x_vcnt, s_vcnt;

  always #5 PCK = ~PCK;

  disp_timing_gen u_vga (
    .PCK(PCK), .RST(RST), .PAT_SEL(PAT_SEL),
    .OUT_R(d_r), .OUT_G(d_g), .OUT_B(d_b), .OUT_HS(d_hs), .OUT_VS(d_vs), .OUT_DE(d_de),
    .HCNT(d_hcnt), .VCNT(d_vcnt), .FRAME_START(d_fs));

  disp_timing_gen #(
    .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
    .V_ACTIVE(768), .V_FP(3), .V_SYNC(6), .V_BP(29), .SYNC_POL(1'b0)
  ) u_xga (
    .PCK(PCK), .RST(RST), .PAT_SEL(PAT_SEL),
    .OUT_R(x_r), .OUT_G(x_g), .OUT_B(x_b), .OUT_HS(x_hs), .OUT_VS(x_vs), .OUT_DE(x_de),
    .HCNT(x_hcnt), .VCNT(x_vcnt), .FRAME_START(x_fs));

  disp_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP), .SYNC_POL(SPOL)
  ) u_small (
    .PCK(PCK), .RST(RST), .PAT_SEL(PAT_SEL),
    .OUT_R(s_r), .OUT_G(s_g), .OUT_B(s_b), .OUT_HS(s_hs), .OUT_VS(s_vs), .OUT_DE(s_de),
    .HCNT(s_hcnt), .VCNT(s_vcnt), .FRAME_START(s_fs));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: index of the pixel presented since reset, and
  // the pattern chosen at the start of the current frame.
  int m_k   = 0;
  int m_cur = 0;
  int m_pat = 0;
  bit m_rst = 1'b1;

  function automatic logic [23:0] bar_ref(input int idx);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[idx];
  endfunction

  function automatic logic [23:0] grid_fix(input int h, input int v, input int ha,
                                           input int va, input logic [23:0] c);
`ifdef DISP_TIMING_GRID_EN
    if (h < ha && v < va && (h % 64 == 0 || v % 64 == 0 || h == ha - 1 || v == va - 1))
      return 24'hFFFFFF;
`endif
    return c;
  endfunction

  function automatic logic [23:0] ref_rgb(input int h, input int v, input int pat,
                                          input int ha, input int va);
    logic [23:0] c;
    if (h >= ha || v >= va) return 24'h0;
    case (pat)
      0:       c = bar_ref(h / (ha / 8));
      1:       c = {3{8'(h % 256)}};
      2:       c = (((h / 16) % 2) != ((v / 16) % 2)) ? 24'hFFFFFF : 24'h0;
      default: c = 24'h0;
    endcase
    return grid_fix(h, v, ha, va, c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance the model, then compare the small instance.
  task automatic step();
    int h, v;
    logic [23:0] e_rgb;
    logic e_de, e_hs, e_vs, e_fs;
    int e_h, e_v;
    @(posedge PCK);
    if (RST) begin
      m_rst = 1'b1;
      m_k   = 0;
    end else begin
      m_rst = 1'b0;
      m_cur = m_k;
      if (m_k % SFRAME == 0) m_pat = int'(PAT_SEL);
      m_k++;
    end
    #1;
    cyc++;
    if (m_rst) begin
      e_rgb = 24'h0; e_de = 1'b0; e_hs = !SPOL; e_vs = !SPOL; e_h = 0; e_v = 0; e_fs = 1'b0;
    end else begin
      h = m_cur % SHT;
      v = (m_cur / SHT) % SVT;
      e_h = h; e_v = v;
      e_de  = (h < SHA) && (v < SVA);
      e_hs  = (h >= SHA + SHFP && h < SHA + SHFP + SHS) ? SPOL : !SPOL;
      e_vs  = (v >= SVA + SVFP && v < SVA + SVFP + SVS) ? SPOL : !SPOL;
      e_fs  = (h == 0) && (v == 0);
      e_rgb = ref_rgb(h, v, m_pat, SHA, SVA);
    end
    n_cmp++;
    if ({s_r, s_g, s_b} !== e_rgb || s_de !== e_de || s_hs !== e_hs || s_vs !== e_vs ||
        s_fs !== e_fs || int'(s_hcnt) != e_h || int'(s_vcnt) != e_v) begin
      n_bad++;
      $display("FAIL small_model cyc=%0d: got h=%0d v=%0d de=%b hs=%b vs=%b fs=%b rgb=%h, expected h=%0d v=%0d de=%b hs=%b vs=%b fs=%b rgb=%h",
               cyc, s_hcnt, s_vcnt, s_de, s_hs, s_vs, s_fs, {s_r, s_g, s_b},
               e_h, e_v, e_de, e_hs, e_vs, e_fs, e_rgb);
    end
  endtask

  typedef struct {
    int          h;
    logic [23:0] rgb;
    logic        de;
    logic        hs;
  } vec_t;

  initial begin
    vec_t tbl [14];
    int   budget, c_fall, de_cnt, fs_cnt;
    logic prev;

    // Line-1 checkpoints for the default instance with colour bars.
    tbl[0]  = '{79,  24'hFFFFFF, 1'b1, 1'b1};
    tbl[1]  = '{80,  24'hFFFF00, 1'b1, 1'b1};
    tbl[2]  = '{159, 24'hFFFF00, 1'b1, 1'b1};
    tbl[3]  = '{160, 24'h00FFFF, 1'b1, 1'b1};
    tbl[4]  = '{400, 24'hFF0000, 1'b1, 1'b1};
    tbl[5]  = '{559, 24'h0000FF, 1'b1, 1'b1};
    tbl[6]  = '{560, 24'h000000, 1'b1, 1'b1};
    tbl[7]  = '{639, 24'h000000, 1'b1, 1'b1};
    tbl[8]  = '{640, 24'h000000, 1'b0, 1'b1};
    tbl[9]  = '{655, 24'h000000, 1'b0, 1'b1};
    tbl[10] = '{656, 24'h000000, 1'b0, 1'b0};
    tbl[11] = '{751, 24'h000000, 1'b0, 1'b0};
    tbl[12] = '{752, 24'h000000, 1'b0, 1'b1};
    tbl[13] = '{799, 24'h000000, 1'b0, 1'b1};

    RST = 1'b1;
    PAT_SEL = 2'd0;
    repeat (3) step();
    check("rst_de", d_de, 1'b0);
    check("rst_rgb", {d_r, d_g, d_b}, 24'h0);
    check("rst_hs", d_hs, 1'b1);
    check("rst_vs", d_vs, 1'b1);
    check("rst_hcnt", d_hcnt, 0);
    check("rst_vcnt", d_vcnt, 0);
    check("rst_fs", d_fs, 1'b0);

    RST = 1'b0;
    step();
    check("first_fs", d_fs, 1'b1);
    check("first_de", d_de, 1'b1);
    check("first_hcnt", d_hcnt, 0);
    check("first_vcnt", d_vcnt, 0);
    check("first_rgb", {d_r, d_g, d_b}, grid_fix(0, 0, 640, 480, 24'hFFFFFF));
    check("xga_first_fs", x_fs, 1'b1);

    for (int i = 0; i < 14; i++) begin
      budget = 2000;
      while (!(int'(d_hcnt) == tbl[i].h && d_vcnt == 10'd1) && budget > 0) begin
        step();
        budget--;
      end
      check($sformatf("tbl%0d_reached", i), budget > 0, 1'b1);
      check($sformatf("tbl%0d_rgb", i), {d_r, d_g, d_b}, grid_fix(tbl[i].h, 1, 640, 480, tbl[i].rgb));
      check($sformatf("tbl%0d_de", i), d_de, tbl[i].de);
      check($sformatf("tbl%0d_hs", i), d_hs, tbl[i].hs);
      check($sformatf("tbl%0d_vs", i), d_vs, 1'b1);
    end

    // Default HS: fall at 656, 96 cycles low, period 800.
    budget = 2000;
    do begin prev = d_hs; step(); budget--; end while (!(prev && !d_hs) && budget > 0);
    check("vga_hs_fall_seen", budget > 0, 1'b1);
    check("vga_hs_fall_hcnt", d_hcnt, 656);
    c_fall = cyc;
    budget = 2000;
    do begin prev = d_hs; step(); budget--; end while (!(!prev && d_hs) && budget > 0);
    check("vga_hs_rise_hcnt", d_hcnt, 752);
    check("vga_hs_width", cyc - c_fall, 96);
    budget = 2000;
    do begin prev = d_hs; step(); budget--; end while (!(prev && !d_hs) && budget > 0);
    check("vga_hs_period", cyc - c_fall, 800);

    budget = 2000;
    while (d_hcnt != 11'd0 && budget > 0) begin step(); budget--; end
    de_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      de_cnt += int'(d_de);
      step();
    end
    check("vga_de_per_line", de_cnt, 640);

    // XGA override: HS fall at 1048, 136 low, period 1344.
    budget = 3000;
    do begin prev = x_hs; step(); budget--; end while (!(prev && !x_hs) && budget > 0);
    check("xga_hs_fall_hcnt", x_hcnt, 1048);
    c_fall = cyc;
    budget = 3000;
    do begin prev = x_hs; step(); budget--; end while (!(!prev && x_hs) && budget > 0);
    check("xga_hs_width", cyc - c_fall, 136);
    budget = 3000;
    do begin prev = x_hs; step(); budget--; end while (!(prev && !x_hs) && budget > 0);
    check("xga_hs_period", cyc - c_fall, 1344);
    budget = 10000;
    while (!(x_hcnt == 11'd64 && x_vcnt == 10'd5) && budget > 0) begin step(); budget--; end
    check("xga_px64_5_reached", budget > 0, 1'b1);
    check("xga_px64_5_rgb", {x_r, x_g, x_b}, 24'hFFFFFF);

    // Small raster: one full frame of DE and FRAME_START counting.
    budget = SFRAME + 10;
    while (!s_fs && budget > 0) begin step(); budget--; end
    check("small_fs_seen", budget > 0, 1'b1);
    de_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < SFRAME; i++) begin
      de_cnt += int'(s_de);
      fs_cnt += int'(s_fs);
      step();
    end
    check("small_de_per_frame", de_cnt, SHA * SVA);
    check("small_fs_per_frame", fs_cnt, 1);
    check("small_fs_period", s_fs, 1'b1);

    // Pattern switch mid-frame: current frame keeps bars, next frame is checkerboard.
    budget = SFRAME + 10;
    while (s_vcnt != 10'd10 && budget > 0) begin step(); budget--; end
    PAT_SEL = 2'd2;
    budget = SFRAME + 10;
    while (!(s_hcnt == 11'd8 && s_vcnt == 10'd20) && budget > 0) begin step(); budget--; end
    check("switch_same_frame_rgb", {s_r, s_g, s_b}, grid_fix(8, 20, SHA, SVA, 24'hFFFF00));
    budget = SFRAME + 10;
    while (!s_fs && budget > 0) begin step(); budget--; end
    check("switch_px0_0_rgb", {s_r, s_g, s_b}, grid_fix(0, 0, SHA, SVA, 24'h000000));
    budget = 100;
    while (s_hcnt != 11'd16 && budget > 0) begin step(); budget--; end
    check("switch_px16_0_rgb", {s_r, s_g, s_b}, 24'hFFFFFF);

    // Single-cycle reset mid-frame.
    budget = SFRAME + 10;
    while (!(s_hcnt == 11'd30 && s_vcnt == 10'd20) && budget > 0) begin step(); budget--; end
    check("midrst_reached", budget > 0, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midrst_de", s_de, 1'b0);
    check("midrst_hs", s_hs, !SPOL);
    check("midrst_vs", s_vs, !SPOL);
    check("midrst_vga_de", d_de, 1'b0);
    check("midrst_vga_hs", d_hs, 1'b1);
    check("midrst_vga_vs", d_vs, 1'b1);
    step();
    check("postrst_fs", s_fs, 1'b1);
    check("postrst_hcnt", s_hcnt, 0);
    check("postrst_vcnt", s_vcnt, 0);
    check("postrst_vga_fs", d_fs, 1'b1);

    // Randomised pattern changes and occasional resets, checked by the model.
    for (int i = 0; i < 25000; i++) begin
      if ($urandom_range(0, 199) == 0) PAT_SEL = 2'($urandom_range(0, 3));
      RST = ($urandom_range(0, 4999) == 0);
      step();
    end
    RST = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
